// File: rtl/writeback_unit_if.sv
// Result-collection bus between the ALU/LSU producers, the writeback unit and register_file.
// The slave side belongs to the writeback unit; the master side drives results and observes writes.
interface writeback_unit_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_data;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_addr;
    logic [31:0] lsu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_offset;

    logic        reg_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    modport master (
        output alu_valid, alu_rd_addr, alu_data,
        output lsu_valid, lsu_rd_addr, lsu_data, lsu_funct3, lsu_offset,
        input  alu_ready, lsu_ready,
        input  reg_wr_en, rd_addr, wr_data, busy
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_data,
        input  lsu_valid, lsu_rd_addr, lsu_data, lsu_funct3, lsu_offset,
        output alu_ready, lsu_ready,
        output reg_wr_en, rd_addr, wr_data, busy
    );
endinterface

// File: rtl/writeback_unit.sv
// In-order result FIFO feeding the register_file write port, with load extension at enqueue
// and a pending-write scoreboard for decode RAW stalls.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    writeback_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;

    logic [4:0]  rd_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic             empty;
    logic             lsu_push;
    logic             alu_push;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;
    logic [31:0]      lsu_ext;
    logic [31:0]      busy_vec;

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  offset
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  result = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  result = {{16{half_sel[15]}}, half_sel};
            3'b100:  result = {24'd0, byte_sel};
            3'b101:  result = {16'd0, half_sel};
            default: result = word;
        endcase
        return result;
    endfunction

    // Readiness depends only on the pre-edge occupancy; LSU gets the last free slot.
    assign free          = DEPTH_C - count;
    assign empty         = (count == '0);
    assign bus.lsu_ready = (free != '0);
    assign bus.alu_ready = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~bus.lsu_valid);

    assign lsu_push = bus.lsu_valid & bus.lsu_ready;
    assign alu_push = bus.alu_valid & bus.alu_ready;
    assign pop      = ~empty;
    assign alu_slot = lsu_push ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign lsu_ext  = load_extend(bus.lsu_data, bus.lsu_funct3, bus.lsu_offset);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(lsu_push) + PTR_W'(alu_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
        end
    end

    // LSU is the older op, so it takes the lower slot when both push together.
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            rd_mem[wr_ptr]   <= bus.lsu_rd_addr;
            data_mem[wr_ptr] <= lsu_ext;
        end
        if (alu_push) begin
            rd_mem[alu_slot]   <= bus.alu_rd_addr;
            data_mem[alu_slot] <= bus.alu_data;
        end
    end

    assign bus.reg_wr_en = ~empty & (rd_mem[rd_ptr] != 5'd0);
    assign bus.rd_addr   = empty ? 5'd0  : rd_mem[rd_ptr];
    assign bus.wr_data   = empty ? 32'd0 : data_mem[rd_ptr];

    always_comb begin
        logic [PTR_W-1:0] idx;
        busy_vec = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                busy_vec[rd_mem[idx]] = 1'b1;
            end
        end
        busy_vec[0] = 1'b0;
    end

    assign bus.busy = busy_vec;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: table of single-result vectors plus multi-cycle
// sequences for simultaneous pushes, duplicates, backpressure and reset mid-drain.
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    writeback_unit_if bus ();

    writeback_unit #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_lsu;
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    logic [36:0] wr_log[$];
    logic [36:0] exp_q[$];
    logic [31:0] rf_model[32];

    always @(negedge clk) begin
        if (bus.reg_wr_en) begin
            wr_log.push_back({bus.rd_addr, bus.wr_data});
            rf_model[bus.rd_addr] <= bus.wr_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd_addr = 5'd0;
        bus.alu_data    = 32'd0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd_addr = 5'd0;
        bus.lsu_data    = 32'd0;
        bus.lsu_funct3  = 3'b010;
        bus.lsu_offset  = 2'd0;
    endtask

    task automatic drive_bp(input int li, input int ai);
        bus.lsu_valid   = (li < 6);
        bus.lsu_rd_addr = 5'(8 + li);
        bus.lsu_data    = 32'h1000 + 32'(li);
        bus.lsu_funct3  = 3'b010;
        bus.lsu_offset  = 2'd0;
        bus.alu_valid   = (ai < 4);
        bus.alu_rd_addr = 5'(20 + ai);
        bus.alu_data    = 32'h2000 + 32'(ai);
    endtask

    function automatic logic [31:0] onehot(input logic [4:0] rd);
        return (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
    endfunction

    initial begin
        int li, ai, cnt_m, base;
        logic la, aa, er_l, er_a;

        tests = 0;
        fails = 0;
        for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;

        //          lsu   f3      off  rd     data           expected
        vecs[0]  = '{1'b0, 3'b000, 2'd0, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 3'b000, 2'd3, 5'd1,  32'h80FF7F01, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 3'b100, 2'd1, 5'd2,  32'h80FF7F01, 32'h0000007F};
        vecs[3]  = '{1'b1, 3'b001, 2'd2, 5'd9,  32'h80FF7F01, 32'hFFFF80FF};
        vecs[4]  = '{1'b1, 3'b101, 2'd0, 5'd10, 32'h80FF7F01, 32'h00007F01};
        vecs[5]  = '{1'b1, 3'b010, 2'd2, 5'd31, 32'h80FF7F01, 32'h80FF7F01};
        vecs[6]  = '{1'b1, 3'b000, 2'd2, 5'd6,  32'h80FF7F01, 32'hFFFFFFFF};
        vecs[7]  = '{1'b1, 3'b001, 2'd1, 5'd11, 32'h80FF7F01, 32'h00007F01};
        vecs[8]  = '{1'b1, 3'b101, 2'd3, 5'd12, 32'h80FF7F01, 32'h000080FF};
        vecs[9]  = '{1'b1, 3'b011, 2'd1, 5'd13, 32'h80FF7F01, 32'h80FF7F01};
        vecs[10] = '{1'b0, 3'b000, 2'd0, 5'd0,  32'h12345678, 32'h12345678};
        vecs[11] = '{1'b1, 3'b100, 2'd0, 5'd0,  32'h80FF7F01, 32'h00000001};

        // Reset state
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst wr_en",     32'(bus.reg_wr_en), 32'd0);
        chk("rst rd_addr",   32'(bus.rd_addr),   32'd0);
        chk("rst wr_data",   bus.wr_data,        32'd0);
        chk("rst busy",      bus.busy,           32'd0);
        chk("rst alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst lsu_ready", 32'(bus.lsu_ready), 32'd1);

        // Single-result vectors
        for (int v = 0; v < 12; v++) begin
            tick();
            idle();
            if (vecs[v].is_lsu) begin
                bus.lsu_valid   = 1'b1;
                bus.lsu_rd_addr = vecs[v].rd;
                bus.lsu_data    = vecs[v].data;
                bus.lsu_funct3  = vecs[v].funct3;
                bus.lsu_offset  = vecs[v].offset;
            end else begin
                bus.alu_valid   = 1'b1;
                bus.alu_rd_addr = vecs[v].rd;
                bus.alu_data    = vecs[v].data;
            end
            @(negedge clk);
            chk($sformatf("vec%0d ready", v),
                32'(vecs[v].is_lsu ? bus.lsu_ready : bus.alu_ready), 32'd1);
            tick();
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d wr_en", v),   32'(bus.reg_wr_en), 32'(vecs[v].rd != 5'd0));
            chk($sformatf("vec%0d rd_addr", v), 32'(bus.rd_addr),   32'(vecs[v].rd));
            chk($sformatf("vec%0d wr_data", v), bus.wr_data,        vecs[v].exp_data);
            chk($sformatf("vec%0d busy", v),    bus.busy,           onehot(vecs[v].rd));
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d drained wr_en", v), 32'(bus.reg_wr_en), 32'd0);
            chk($sformatf("vec%0d drained busy", v),  bus.busy,           32'd0);
            chk($sformatf("vec%0d drained data", v),  bus.wr_data,        32'd0);
        end

        // Simultaneous LSU + ALU into an empty FIFO
        tick();
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd_addr = 5'd3; bus.lsu_data = 32'hAAAA0003;
        bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd4; bus.alu_data = 32'hBBBB0004;
        @(negedge clk);
        chk("sim lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("sim alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("sim c1 rd",   32'(bus.rd_addr), 32'd3);
        chk("sim c1 data", bus.wr_data,      32'hAAAA0003);
        chk("sim c1 busy", bus.busy,         32'h18);
        tick();
        @(negedge clk);
        chk("sim c2 rd",   32'(bus.rd_addr), 32'd4);
        chk("sim c2 data", bus.wr_data,      32'hBBBB0004);
        chk("sim c2 busy", bus.busy,         32'h10);
        tick();
        @(negedge clk);
        chk("sim c3 busy",  bus.busy,           32'd0);
        chk("sim c3 wr_en", 32'(bus.reg_wr_en), 32'd0);

        // Duplicate destination: last write wins, busy held until both drain
        tick();
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd_addr = 5'd7; bus.lsu_data = 32'h1;
        bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd7; bus.alu_data = 32'h2;
        tick();
        idle();
        @(negedge clk);
        chk("dup c1 data", bus.wr_data, 32'h1);
        chk("dup c1 busy", bus.busy,    32'h80);
        tick();
        @(negedge clk);
        chk("dup c2 data", bus.wr_data, 32'h2);
        chk("dup c2 busy", bus.busy,    32'h80);
        tick();
        @(negedge clk);
        chk("dup c3 busy", bus.busy,    32'd0);
        chk("dup x7",      rf_model[7], 32'h2);

        // Backpressure with both sources persistently valid
        tick();
        li = 0; ai = 0; cnt_m = 0;
        base = wr_log.size();
        exp_q.delete();
        drive_bp(li, ai);
        for (int c = 0; c < 40 && (li < 6 || ai < 4); c++) begin
            @(negedge clk);
            er_l = (cnt_m < 4);
            er_a = ((4 - cnt_m) >= 2) || (((4 - cnt_m) == 1) && !bus.lsu_valid);
            if (bus.lsu_valid) chk($sformatf("bp c%0d lsu_ready", c), 32'(bus.lsu_ready), 32'(er_l));
            if (bus.alu_valid) chk($sformatf("bp c%0d alu_ready", c), 32'(bus.alu_ready), 32'(er_a));
            la = bus.lsu_valid & bus.lsu_ready;
            aa = bus.alu_valid & bus.alu_ready;
            @(posedge clk);
            if (la) exp_q.push_back({bus.lsu_rd_addr, bus.lsu_data});
            if (aa) exp_q.push_back({bus.alu_rd_addr, bus.alu_data});
            cnt_m = cnt_m + int'(la) + int'(aa) - ((cnt_m != 0) ? 1 : 0);
            #1;
            if (la) li++;
            if (aa) ai++;
            drive_bp(li, ai);
        end
        chk("bp lsu all accepted", 32'(li), 32'd6);
        chk("bp alu all accepted", 32'(ai), 32'd4);
        idle();
        repeat (6) tick();
        chk("bp write count", 32'(wr_log.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && (base + k) < wr_log.size(); k++) begin
            chk($sformatf("bp write%0d rd", k),   32'(wr_log[base + k][36:32]), 32'(exp_q[k][36:32]));
            chk($sformatf("bp write%0d data", k), wr_log[base + k][31:0],        exp_q[k][31:0]);
        end

        // Reset while three entries are queued and draining
        tick();
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd_addr = 5'd1; bus.lsu_data = 32'hC1;
        bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd2; bus.alu_data = 32'hC2;
        tick();
        bus.lsu_rd_addr = 5'd3; bus.lsu_data = 32'hC3;
        bus.alu_rd_addr = 5'd4; bus.alu_data = 32'hC4;
        tick();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2 pre busy", bus.busy, 32'h1C);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_log.size();
        chk("rst2 wr_en",     32'(bus.reg_wr_en), 32'd0);
        chk("rst2 busy",      bus.busy,           32'd0);
        chk("rst2 alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst2 lsu_ready", 32'(bus.lsu_ready), 32'd1);
        repeat (5) tick();
        @(negedge clk);
        chk("rst2 no late writes", 32'(wr_log.size() - base), 32'd0);
        chk("rst2 busy later",     bus.busy,                  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
